// File: rtl/packet_stats_pkg.sv
// Shared constants and counter-set type for packet_stats.
// Min/max fields exist only when PACKET_STATS_MINMAX_EN is defined.
package packet_stats_pkg;

  localparam logic [2:0] FLD_PKT      = 3'd0;
  localparam logic [2:0] FLD_BYTES_LO = 3'd1;
  localparam logic [2:0] FLD_BYTES_HI = 3'd2;
  localparam logic [2:0] FLD_ERR      = 3'd3;
  localparam logic [2:0] FLD_MIN      = 3'd4;
  localparam logic [2:0] FLD_MAX      = 3'd5;

  localparam logic [7:0] ADDR_UNK    = 8'hF8;
  localparam int         ADDR_STRIDE = 8;

  // Stored at maximum widths; bits above CW/BW are always zero.
  typedef struct packed {
    logic [31:0] pkt;
    logic [47:0] bytes;
    logic [31:0] err;
`ifdef PACKET_STATS_MINMAX_EN
    logic [15:0] min;
    logic [15:0] max;
`endif
  } ctr_set_t;

  function automatic ctr_set_t ctr_clear();
    ctr_set_t c;
    c = '0;
`ifdef PACKET_STATS_MINMAX_EN
    c.min = 16'hFFFF;
`endif
    return c;
  endfunction

endpackage

// File: rtl/packet_stats_sat_add.sv
// Saturating adder: i_a + zero-extended i_b, pinned at all-ones on overflow.
// Used by every live counter in packet_stats.
module packet_stats_sat_add #(
  parameter int W  = 32,
  parameter int IW = 16
) (
  input  logic [W-1:0]  i_a,
  input  logic [IW-1:0] i_b,
  output logic [W-1:0]  o_sum
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {{(W + 1 - IW){1'b0}}, i_b};
  assign o_sum  = w_full[W] ? '1 : w_full[W-1:0];

endmodule

// File: rtl/packet_stats.sv
// Per-port packet/byte/error statistics with a snapshot shadow bank and read port.
// Optional per-port min/max length tracking under PACKET_STATS_MINMAX_EN.
module packet_stats
  import packet_stats_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int CW    = 32,
  parameter int BW    = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] axis_in_tdata,
  input  logic        axis_in_tuser,
  input  logic        axis_in_tvalid,
  input  logic        snapshot,
  input  logic        clear,
  input  logic        rd_strobe,
  input  logic [7:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid
);

  // Stream contract: no tready, so every cycle with axis_in_tvalid=1 is a
  // consumed beat; the pipeline never stalls and never drops a beat.
  logic        r_stg_valid;
  logic [7:0]  r_stg_port;
  logic [15:0] r_stg_len;
  logic        r_stg_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_port  <= '0;
      r_stg_len   <= '0;
      r_stg_err   <= 1'b0;
    end else begin
      r_stg_valid <= axis_in_tvalid;
      if (axis_in_tvalid) begin
        r_stg_port <= axis_in_tdata[23:16];
        r_stg_len  <= axis_in_tdata[15:0];
        r_stg_err  <= axis_in_tuser;
      end
    end
  end

  logic w_in_range;
  logic w_unk_hit;
  assign w_in_range = r_stg_valid && (r_stg_port < 8'(PORTS));
  assign w_unk_hit  = r_stg_valid && !(r_stg_port < 8'(PORTS));

  ctr_set_t w_shadow_arr [PORTS];

  // Clear is folded in ahead of the adders so a same-edge beat counts post-clear.
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    ctr_set_t      r_live, r_shadow, w_base, w_next;
    logic          w_hit;
    logic [CW-1:0] w_pkt_sum, w_err_sum;
    logic [BW-1:0] w_byte_sum;

    assign w_hit  = w_in_range && (r_stg_port == 8'(p));
    assign w_base = clear ? ctr_clear() : r_live;

    packet_stats_sat_add #(.W(CW), .IW(1)) u_pkt (
      .i_a(w_base.pkt[CW-1:0]), .i_b(1'b1), .o_sum(w_pkt_sum));
    packet_stats_sat_add #(.W(BW), .IW(16)) u_byte (
      .i_a(w_base.bytes[BW-1:0]), .i_b(r_stg_len), .o_sum(w_byte_sum));
    packet_stats_sat_add #(.W(CW), .IW(1)) u_err (
      .i_a(w_base.err[CW-1:0]), .i_b(r_stg_err), .o_sum(w_err_sum));

    always_comb begin
      w_next = w_base;
      if (w_hit) begin
        w_next.pkt   = 32'(w_pkt_sum);
        w_next.bytes = 48'(w_byte_sum);
        w_next.err   = 32'(w_err_sum);
`ifdef PACKET_STATS_MINMAX_EN
        if (r_stg_len < w_base.min) w_next.min = r_stg_len;
        if (r_stg_len > w_base.max) w_next.max = r_stg_len;
`endif
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_live   <= ctr_clear();
        r_shadow <= ctr_clear();
      end else begin
        r_live <= w_next;
        if (snapshot) r_shadow <= r_live;
      end
    end

    assign w_shadow_arr[p] = r_shadow;
  end

  logic [CW-1:0] r_live_unk, r_shadow_unk, w_unk_base, w_unk_sum;

  assign w_unk_base = clear ? '0 : r_live_unk;

  packet_stats_sat_add #(.W(CW), .IW(1)) u_unk (
    .i_a(w_unk_base), .i_b(w_unk_hit), .o_sum(w_unk_sum));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live_unk   <= '0;
      r_shadow_unk <= '0;
    end else begin
      r_live_unk <= w_unk_sum;
      if (snapshot) r_shadow_unk <= r_live_unk;
    end
  end

  // Address = port*ADDR_STRIDE + field, so port is addr[7:3] and field addr[2:0].
  logic [4:0]  w_rd_port;
  logic [2:0]  w_rd_fld;
  ctr_set_t    w_sel;
  logic        w_sel_ok;
  logic [31:0] w_rd_word;

  assign w_rd_port = rd_addr[7:3];
  assign w_rd_fld  = rd_addr[2:0];

  always_comb begin
    w_sel    = ctr_clear();
    w_sel_ok = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_rd_port == 5'(p)) begin
        w_sel    = w_shadow_arr[p];
        w_sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (rd_addr == ADDR_UNK) begin
      w_rd_word = 32'(r_shadow_unk);
    end else if (w_sel_ok) begin
      case (w_rd_fld)
        FLD_PKT:      w_rd_word = w_sel.pkt;
        FLD_BYTES_LO: w_rd_word = w_sel.bytes[31:0];
        FLD_BYTES_HI: w_rd_word = {16'h0000, w_sel.bytes[47:32]};
        FLD_ERR:      w_rd_word = w_sel.err;
`ifdef PACKET_STATS_MINMAX_EN
        FLD_MIN:      w_rd_word = {16'h0000, w_sel.min};
        FLD_MAX:      w_rd_word = {16'h0000, w_sel.max};
`endif
        default:      w_rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_strobe;
      if (rd_strobe) rd_data <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_packet_stats.sv
// Directed, table-driven bench for packet_stats (default PORTS=4, CW=32, BW=48).
// Expected min/max values follow PACKET_STATS_MINMAX_EN when it is defined.
module tb_packet_stats;

`ifdef PACKET_STATS_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [23:0] axis_in_tdata;
  logic        axis_in_tuser;
  logic        axis_in_tvalid;
  logic        snapshot;
  logic        clear;
  logic        rd_strobe;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  packet_stats #(.PORTS(4), .CW(32), .BW(48)) dut (
    .clk(clk), .reset(reset),
    .axis_in_tdata(axis_in_tdata), .axis_in_tuser(axis_in_tuser),
    .axis_in_tvalid(axis_in_tvalid),
    .snapshot(snapshot), .clear(clear),
    .rd_strobe(rd_strobe), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Stand-alone adders for the saturation boundaries no stream can reach in time.
  logic [47:0] sa48_a, sa48_s;
  logic [15:0] sa48_b;
  logic [31:0] sa32_a, sa32_s;
  logic        sa32_b;

  packet_stats_sat_add #(.W(48), .IW(16)) u_sat48 (.i_a(sa48_a), .i_b(sa48_b), .o_sum(sa48_s));
  packet_stats_sat_add #(.W(32), .IW(1))  u_sat32 (.i_a(sa32_a), .i_b(sa32_b), .o_sum(sa32_s));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: all entered and left at a falling edge
  task automatic beat(input int p, input int len, input bit err);
    axis_in_tdata  = {8'(p), 16'(len)};
    axis_in_tuser  = err;
    axis_in_tvalid = 1'b1;
    @(negedge clk);
    axis_in_tvalid = 1'b0;
    axis_in_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit s, input bit c);
    snapshot = s;
    clear    = c;
    @(negedge clk);
    snapshot = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic read_chk(input int a, input logic [31:0] exp, input string name);
    rd_addr   = 8'(a);
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
    check({name, " rd_valid"}, 64'(rd_valid), 64'd1);
    check(name, 64'(rd_data), 64'(exp));
  endtask

  // scoreboard table for the first traffic pattern
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  localparam int NV = 14;
  rd_vec_t vecs [NV];

  initial begin
    vecs[0]  = '{8'h00, 32'd2};
    vecs[1]  = '{8'h01, 32'd300};
    vecs[2]  = '{8'h02, 32'd0};
    vecs[3]  = '{8'h03, 32'd0};
    vecs[4]  = '{8'h04, MM ? 32'd100 : 32'd0};
    vecs[5]  = '{8'h05, MM ? 32'd200 : 32'd0};
    vecs[6]  = '{8'h06, 32'd0};
    vecs[7]  = '{8'h08, 32'd1};
    vecs[8]  = '{8'h0B, 32'd1};
    vecs[9]  = '{8'h10, 32'd0};
    vecs[10] = '{8'h1C, MM ? 32'h0000FFFF : 32'd0};
    vecs[11] = '{8'hF8, 32'd0};
    vecs[12] = '{8'h20, 32'd0};
    vecs[13] = '{8'h09, 32'd64};

    reset = 1'b1;
    axis_in_tdata = '0; axis_in_tuser = 1'b0; axis_in_tvalid = 1'b0;
    snapshot = 1'b0; clear = 1'b0; rd_strobe = 1'b0; rd_addr = '0;
    sa48_a = '0; sa48_b = '0; sa32_a = '0; sa32_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rd_valid", 64'(rd_valid), 64'd0);
    check("reset rd_data", 64'(rd_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // basic accumulation across two ports
    beat(0, 100, 1'b0);
    beat(0, 200, 1'b0);
    beat(1, 64, 1'b1);
    idle(1);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < NV; i++)
      read_chk(vecs[i].addr, vecs[i].exp, $sformatf("basic vec%0d addr 0x%02h", i, vecs[i].addr));
    idle(1);
    check("rd_valid single cycle", 64'(rd_valid), 64'd0);
    check("rd_data held", 64'(rd_data), 64'd64);

    // 1000 back-to-back beats on one port
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) beat(2, 1500, 1'b0);
    idle(1);
    pulse(1'b1, 1'b0);
    read_chk(8'h10, 32'd1000, "burst pkt");
    read_chk(8'h11, 32'd1500000, "burst bytes_lo");
    read_chk(8'h12, 32'd0, "burst bytes_hi");
    read_chk(8'h13, 32'd0, "burst err");
    read_chk(8'h15, MM ? 32'd1500 : 32'd0, "burst max");
    read_chk(8'h00, 32'd0, "burst port0 cleared");

    // out-of-range port
    pulse(1'b0, 1'b1);
    beat(7, 50, 1'b1);
    idle(1);
    pulse(1'b1, 1'b0);
    read_chk(8'hF8, 32'd1, "unk cnt");
    for (int p = 0; p < 4; p++) begin
      read_chk(p * 8, 32'd0, $sformatf("unk port%0d pkt", p));
      read_chk(p * 8 + 3, 32'd0, $sformatf("unk port%0d err", p));
    end
    read_chk(8'h38, 32'd0, "unk port7 unmapped");

    // update, clear and snapshot on the same edge
    pulse(1'b0, 1'b1);
    repeat (5) beat(0, 10, 1'b0);
    beat(0, 77, 1'b1);
    pulse(1'b1, 1'b1);
    read_chk(8'h00, 32'd5, "rac shadow pkt");
    read_chk(8'h01, 32'd50, "rac shadow bytes");
    read_chk(8'h03, 32'd0, "rac shadow err");
    rd_addr = 8'h00; rd_strobe = 1'b1; snapshot = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0; snapshot = 1'b0;
    check("read with snapshot valid", 64'(rd_valid), 64'd1);
    check("read with snapshot pre-value", 64'(rd_data), 64'd5);
    read_chk(8'h00, 32'd1, "post-clear pkt");
    read_chk(8'h01, 32'd77, "post-clear bytes");
    read_chk(8'h03, 32'd1, "post-clear err");

    // zero-length beat and min/max
    pulse(1'b0, 1'b1);
    beat(3, 60, 1'b0);
    beat(3, 9000, 1'b1);
    beat(3, 0, 1'b0);
    idle(1);
    pulse(1'b1, 1'b0);
    read_chk(8'h18, 32'd3, "zlen pkt");
    read_chk(8'h1B, 32'd1, "zlen err");
    read_chk(8'h1C, 32'd0, "zlen min");
    read_chk(8'h1D, MM ? 32'd9000 : 32'd0, "zlen max");
    read_chk(8'h1E, 32'd0, "field6");
    read_chk(8'h14, MM ? 32'h0000FFFF : 32'd0, "cleared min");
    read_chk(8'h19, 32'd9060, "zlen bytes");

    // saturation boundaries
    sa48_a = 48'hFFFF_FFFF_FFF6; sa48_b = 16'd100; #1;
    check("sat48 overflow", 64'(sa48_s), 64'hFFFF_FFFF_FFFF);
    sa48_a = 48'hFFFF_FFFF_FFFF; sa48_b = 16'd1500; #1;
    check("sat48 sticky", 64'(sa48_s), 64'hFFFF_FFFF_FFFF);
    sa48_a = 48'hFFFF_FFFF_FF9B; sa48_b = 16'd100; #1;
    check("sat48 exact top", 64'(sa48_s), 64'hFFFF_FFFF_FFFF);
    sa48_a = 48'h0000_FFFF_FFFF; sa48_b = 16'd2; #1;
    check("sat48 carry to hi", 64'(sa48_s), 64'h0001_0000_0001);
    sa32_a = 32'hFFFF_FFFF; sa32_b = 1'b1; #1;
    check("sat32 sticky", 64'(sa32_s), 64'h0000_0000_FFFF_FFFF);
    sa32_a = 32'hFFFF_FFFE; sa32_b = 1'b1; #1;
    check("sat32 reach top", 64'(sa32_s), 64'h0000_0000_FFFF_FFFF);
    sa32_a = 32'h0000_0041; sa32_b = 1'b0; #1;
    check("sat32 add zero", 64'(sa32_s), 64'h0000_0000_0000_0041);
    @(negedge clk);

    // reset with a beat held in the stage register
    beat(1, 500, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset rd_data", 64'(rd_data), 64'd0);
    check("midreset rd_valid", 64'(rd_valid), 64'd0);
    reset = 1'b0;
    idle(2);
    pulse(1'b1, 1'b0);
    read_chk(8'h08, 32'd0, "midreset port1 pkt");
    read_chk(8'h09, 32'd0, "midreset port1 bytes");
    read_chk(8'h1C, MM ? 32'h0000FFFF : 32'd0, "midreset min");
    read_chk(8'hF8, 32'd0, "midreset unk");

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_stats.md
Name: packet_stats

Overview:
- Consumes the packet-length stream produced by the packet sensor. Each beat is {port[7:0], length[15:0]} plus an error flag in tuser.
- Keeps per-port packet, byte and error counters, plus a counter of packets for ports outside the configured range.
- Counters are snapshot into a shadow bank, and software reads the shadow bank through a simple read strobe/address port.
- Sits between the packet sensor and the register/readout logic of the rx packet counter design.

Parameters:
- PORTS, 4, number of per-port counter sets; legal range 1..31.
- CW, 32, width of the packet and error counters; legal range 16..32.
- BW, 48, width of the byte counters; legal range 33..48.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- axis_in_tdata  in  24  [23:16] port number, [15:0] packet length in bytes.
- axis_in_tuser  in  1  packet had an error.
- axis_in_tvalid  in  1  beat valid. There is no tready; every valid beat must be accepted.
- snapshot  in  1  single-cycle pulse: copy live counters into the shadow bank.
- clear  in  1  single-cycle pulse: zero all live counters.
- rd_strobe  in  1  read request.
- rd_addr  in  8  read address.
- rd_data  out  32  read result.
- rd_valid  out  1  rd_data valid.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears the input stage register, all live and shadow counters, rd_data and rd_valid to 0.
  - Sets min-length registers to 16'hFFFF.
  - Asserting reset mid-packet-stream discards any beat held in the stage register.
- Stage 1: the input beat is registered when axis_in_tvalid=1. Port decode, in_range = (port < PORTS), and the saturating sums are computed from the registered beat.
- Stage 2, live update on the next edge. For an in-range beat:
  - pkt_cnt += 1.
  - byte_cnt += length, zero-extended to BW.
  - err_cnt += 1 if tuser.
- An out-of-range beat increments unk_cnt (width CW) only.
- Latency: a beat sampled at edge N is visible in the live counters after edge N+1. Back-to-back beats to the same port are fully accumulated; no beat is ever lost.
- Saturation: every counter sticks at all-ones and never wraps. A byte sum that would overflow BW bits is set to all-ones.
- Zero-length beat: counted as a packet, adds 0 bytes.
- Clear:
  - zeroes all live counters, sets min to FFFF and max to 0.
  - If a stage-2 update lands on the same edge, the packet counts as post-clear (for example, pkt_cnt=1 and byte_cnt=length).
- Snapshot: the shadow bank takes the live values present before the edge, so an update landing on the same edge is excluded.
- Snapshot and clear on the same edge give read-and-clear semantics: the shadow bank holds the pre-clear values and the live counters restart.
- Reads:
  - Reads always return shadow-bank values. rd_valid is asserted for one cycle, one cycle after rd_strobe, and rd_data is held until the next read.
  - Address = port*8 + field:
    - field 0: pkt_cnt.
    - field 1: byte_cnt[31:0].
    - field 2: byte_cnt[BW-1:32], zero-padded.
    - field 3: err_cnt.
    - fields 4/5: min/max length (optional feature).
    - fields 6/7: read 0.
  - Address 0xF8 returns unk_cnt. All other unmapped addresses return 0.
  - Counters narrower than 32 bits are zero-extended.
- A read in the same cycle as snapshot returns the pre-snapshot shadow value.

Optional Feature:
- Macro PACKET_STATS_MINMAX_EN.
- When defined:
  - Per-port 16-bit min and max packet length registers are kept, updated in stage 2 alongside the counters.
  - Errored packets are included.
  - Both are snapshotted and cleared with the counters, and read at fields 4 and 5.
  - Min reads FFFF until the first packet after reset or clear.
- When undefined: no min/max registers are built, and fields 4 and 5 read 0.

Decomposition:
- Shared package packet_stats_pkg holds:
  - field index constants (FLD_PKT=0, FLD_BYTES_LO=1, FLD_BYTES_HI=2, FLD_ERR=3, FLD_MIN=4, FLD_MAX=5);
  - ADDR_UNK=8'hF8;
  - the address stride of 8;
  - a typedef for the live counter set (pkt, bytes, err, min, max).
- One sub-module is natural: packet_stats_sat_add, a parameterised saturating adder used for every counter.

Test Plan:
- Reset, then beats {0x00,100},{0x00,200},{0x01,64,tuser=1}, then snapshot → reads give port0 pkt=2, bytes_lo=300; port1 pkt=1, err=1, bytes_lo=64.
- 1000 consecutive valid beats, port 2, length 1500, then snapshot → pkt=1000, bytes_lo=1500000, bytes_hi=0; no beat lost.
- Beat to port 0x07 with PORTS=4 → unk_cnt=1 at 0xF8; all per-port counters remain 0.
- Beat to port 0 lands in stage 2 on the same edge as clear and snapshot → shadow holds the pre-clear pkt count (for example 5), and live pkt=1 (visible after the next snapshot).
- Preload byte_cnt to 2^48-10, then a beat of length 100 → byte_cnt = 2^48-1 and stays there on further beats. pkt_cnt at FFFFFFFF stays FFFFFFFF.
- With PACKET_STATS_MINMAX_EN: lengths 60, 9000, 0 to port 3 → field 4 reads 0, field 5 reads 9000. Before any packet, field 4 reads 0xFFFF. With the macro undefined, both fields read 0.
